// File: rtl/mont_operand_sequencer.sv
// Operand/result sequencer between the 32-word operand buffer
// and the Montgomery multiplier core.
module mont_operand_sequencer #(
  parameter int DATA_WIDTH = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  buf_valid,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_b,
  output logic [DATA_WIDTH-1:0] core_m,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_result,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_we,
  input  logic                  res_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  ovr_err
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_M,
    S_START,
    S_RUN,
    S_WRITE
  } state_t;

  state_t state;
  logic   accepting;

  assign accepting = (state == S_WAIT_A) ||
                     (state == S_WAIT_B) ||
                     (state == S_WAIT_M);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_WAIT_A;
      core_a     <= '0;
      core_b     <= '0;
      core_m     <= '0;
      core_start <= 1'b0;
      res_data   <= '0;
      res_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_WAIT_A: begin
          if (buf_valid) begin
            core_a <= buf_data;
            busy   <= 1'b1;
            state  <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (buf_valid) begin
            core_b <= buf_data;
            state  <= S_WAIT_M;
          end
        end
        S_WAIT_M: begin
          if (buf_valid) begin
            core_m     <= buf_data;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            res_data <= core_result;
            res_we   <= 1'b1;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (res_ack) begin
            res_we <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_WAIT_A;
          end
        end
        default: begin
          state <= S_WAIT_A;
        end
      endcase
      // Loads while the core owns the operands are dropped, not queued.
      if (buf_valid && !accepting) ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mont_operand_sequencer.sv
// Directed bench for mont_operand_sequencer.
// Inputs driven 1ns after rising edge, outputs sampled there too.
module tb_mont_operand_sequencer;

  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] buf_data;
  logic          buf_valid;
  logic [DW-1:0] core_a;
  logic [DW-1:0] core_b;
  logic [DW-1:0] core_m;
  logic          core_start;
  logic          core_done;
  logic [DW-1:0] core_result;
  logic [DW-1:0] res_data;
  logic          res_we;
  logic          res_ack;
  logic          busy;
  logic          done;
  logic          ovr_err;

  int n_run  = 0;
  int n_fail = 0;

  mont_operand_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .buf_data   (buf_data),
    .buf_valid  (buf_valid),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_m     (core_m),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .res_data   (res_data),
    .res_we     (res_we),
    .res_ack    (res_ack),
    .busy       (busy),
    .done       (done),
    .ovr_err    (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d);
    buf_data  = d;
    buf_valid = 1'b1;
    tick();
    buf_valid = 1'b0;
    buf_data  = '0;
  endtask

  task automatic finish_core(input logic [DW-1:0] r);
    core_result = r;
    core_done   = 1'b1;
    tick();
    core_done   = 1'b0;
    core_result = '0;
  endtask

  task automatic ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  logic [DW-1:0] m_val;
  logic [DW-1:0] r_val;
  bit            saw_bad;

  initial begin
    m_val       = ~DW'('hE);
    r_val       = {DW/8{8'hC3}};
    resetn      = 1'b0;
    buf_data    = '0;
    buf_valid   = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    res_ack     = 1'b0;

    // 1 reset
    tick();
    tick();
    check("rst_a", core_a, '0);
    check("rst_m", core_m, '0);
    check("rst_res", res_data, '0);
    check("rst_we", DW'(res_we), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_ovr", DW'(ovr_err), '0);
    check("rst_start", DW'(core_start), '0);
    check("rst_done", DW'(done), '0);
    resetn = 1'b1;
    tick();

    // 2 normal job
    load(DW'(1));
    check("n_a", core_a, DW'(1));
    check("n_busy", DW'(busy), DW'(1));
    check("n_start0", DW'(core_start), '0);
    load(DW'(2));
    check("n_b", core_b, DW'(2));
    check("n_start1", DW'(core_start), '0);
    load(m_val);
    check("n_m", core_m, m_val);
    check("n_start", DW'(core_start), DW'(1));
    tick();
    check("n_start_off", DW'(core_start), '0);
    finish_core(DW'('h5A));
    check("n_res", res_data, DW'('h5A));
    check("n_we", DW'(res_we), DW'(1));
    ack();
    check("n_we_off", DW'(res_we), '0);
    check("n_done", DW'(done), DW'(1));
    check("n_busy_off", DW'(busy), '0);
    tick();
    check("n_done_off", DW'(done), '0);

    // 3 stall
    load(DW'(3));
    load(DW'(4));
    load(m_val);
    tick();
    saw_bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (core_start !== 1'b0 || res_we !== 1'b0) saw_bad = 1'b1;
      tick();
    end
    check("s_core_idle", DW'(saw_bad), '0);
    check("s_busy", DW'(busy), DW'(1));
    finish_core(r_val);
    saw_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (res_we !== 1'b1 || res_data !== r_val) saw_bad = 1'b1;
      tick();
    end
    check("s_we_hold", DW'(saw_bad), '0);
    check("s_res", res_data, r_val);
    check("s_done_wait", DW'(done), '0);
    ack();
    check("s_done", DW'(done), DW'(1));
    tick();

    // 4 overrun
    load(DW'('h11));
    load(DW'('h22));
    load(DW'('h33));
    tick();
    load(DW'('hDEAD));
    check("o_err", DW'(ovr_err), DW'(1));
    check("o_a", core_a, DW'('h11));
    check("o_b", core_b, DW'('h22));
    check("o_m", core_m, DW'('h33));
    finish_core(DW'('h44));
    check("o_res", res_data, DW'('h44));
    ack();
    check("o_done", DW'(done), DW'(1));
    check("o_err_hold", DW'(ovr_err), DW'(1));
    tick();

    // 5 spurious inputs, then back-to-back start
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    load(DW'('h55));
    finish_core(DW'('hBAD));
    check("p_res", res_data, '0);
    check("p_we", DW'(res_we), '0);
    load(DW'('h66));
    check("p_b", core_b, DW'('h66));
    check("p_m_still", DW'(core_start), '0);
    load(DW'('h77));
    check("p_start", DW'(core_start), DW'(1));
    tick();
    ack();
    check("p_ack_done", DW'(done), '0);
    check("p_ack_busy", DW'(busy), DW'(1));
    finish_core(DW'('h88));
    check("p_res2", res_data, DW'('h88));
    tick();
    ack();
    check("p_done", DW'(done), DW'(1));
    load(DW'('h99));
    check("b2b_a", core_a, DW'('h99));
    check("b2b_busy", DW'(busy), DW'(1));
    check("p_ovr", DW'(ovr_err), '0);

    // 6 reset mid-write, then a fresh job
    load(DW'('hAA));
    load(DW'('hBB));
    tick();
    finish_core(DW'('hCC));
    check("r_we", DW'(res_we), DW'(1));
    resetn = 1'b0;
    tick();
    check("r_we_drop", DW'(res_we), '0);
    check("r_a", core_a, '0);
    resetn = 1'b1;
    tick();
    load(DW'(5));
    load(DW'(6));
    load(m_val);
    check("f_start", DW'(core_start), DW'(1));
    tick();
    finish_core(DW'('h7E));
    check("f_res", res_data, DW'('h7E));
    tick();
    ack();
    check("f_done", DW'(done), DW'(1));
    check("f_a", core_a, DW'(5));
    check("f_busy", DW'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
